// File: rtl/rhythm_pkg.sv
// Shared definitions for the rhythm-game chart sequencer: FSM encoding,
// chart entry field layout, lane count and speed codes.
package rhythm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        WAIT,
        SPAWN,
        DONE
    } state_t;

    localparam int NUM_LANES = 4;

    // Chart entry: {END, reserved[2:0], lane mask[3:0], GAP[7:0]}
    localparam int ENTRY_W  = 16;
    localparam int END_BIT  = 15;
    localparam int MASK_LSB = 8;
    localparam int GAP_LSB  = 0;
    localparam int GAP_W    = 8;

    localparam logic [1:0] SPEED_1X = 2'd0;
    localparam logic [1:0] SPEED_2X = 2'd1;
    localparam logic [1:0] SPEED_3X = 2'd2;
    localparam logic [1:0] SPEED_4X = 2'd3;

endpackage

// File: rtl/beat_tick_gen.sv
// Fractional prescaler producing beat ticks at TICK_HZ * (speed+1) from CLK_HZ.
module beat_tick_gen
    import rhythm_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Enable,
    input  logic       i_Clear,
    input  logic [1:0] i_Speed,
    output logic       o_Tick
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int ACC_W = $clog2(DIV + 4);
    localparam logic [ACC_W-1:0] DIV_C = ACC_W'(DIV);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] inc;
    logic [ACC_W-1:0] sum;
    logic             tick_q, tick_d;

    always_comb begin
        inc = ACC_W'(1);
        case (i_Speed)
            SPEED_1X: inc = ACC_W'(1);
            SPEED_2X: inc = ACC_W'(2);
            SPEED_3X: inc = ACC_W'(3);
            SPEED_4X: inc = ACC_W'(4);
        endcase

        sum    = acc_q + inc;
        acc_d  = acc_q;
        tick_d = tick_q;
        // While disabled a pending tick is held, so pausing shifts the
        // whole tick train instead of dropping a tick.
        if (i_Clear) begin
            acc_d  = '0;
            tick_d = 1'b0;
        end else if (i_Enable) begin
            if (sum >= DIV_C) begin
                acc_d  = sum - DIV_C;
                tick_d = 1'b1;
            end else begin
                acc_d  = sum;
                tick_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            acc_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            tick_q <= tick_d;
        end
    end

    assign o_Tick = tick_q & i_Enable;

endmodule

// File: rtl/note_scheduler.sv
// Chart sequencer: walks the chart ROM, waits GAP beat ticks per entry and
// emits a one-cycle lane-mask spawn pulse for each entry.
module note_scheduler
    import rhythm_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int TICK_HZ  = 100,
    parameter int CHART_AW = 8,
    parameter int LANES    = NUM_LANES
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    input  logic                i_Start,
    input  logic                i_Abort,
    input  logic                i_Pause,
    input  logic [1:0]          i_Speed,
    output logic [CHART_AW-1:0] o_Chart_Addr,
    input  logic [ENTRY_W-1:0]  i_Chart_Data,
    output logic [LANES-1:0]    o_Spawn,
    output logic                o_Beat_Tick,
    output logic                o_Busy,
    output logic                o_Done
);

    state_t              state_q, state_d;
    logic [CHART_AW-1:0] addr_q, addr_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [LANES-1:0]    mask_q, mask_d;
    logic [LANES-1:0]    spawn_q, spawn_d;
    logic                beat_q, beat_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                tick;
    logic                gen_enable;
    logic                gen_clear;
    logic                unused_rsvd;

    assign unused_rsvd = ^i_Chart_Data[END_BIT-1:MASK_LSB+LANES];
    assign gen_enable  = (state_q != IDLE) && !i_Pause;

    beat_tick_gen #(
        .CLK_HZ (CLK_HZ),
        .TICK_HZ(TICK_HZ)
    ) u_tick (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_Enable(gen_enable),
        .i_Clear (gen_clear),
        .i_Speed (i_Speed),
        .o_Tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        gap_d   = gap_q;
        mask_d  = mask_q;
        spawn_d = '0;
        done_d  = 1'b0;

        if (i_Abort) begin
            state_d = IDLE;
            addr_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_Start) begin
                        state_d = FETCH;
                        addr_d  = '0;
                    end
                end
                FETCH: begin
                    if (!i_Pause) state_d = LOAD;
                end
                LOAD: begin
                    if (!i_Pause) begin
                        mask_d = i_Chart_Data[MASK_LSB +: LANES];
                        if (i_Chart_Data[END_BIT]) begin
                            state_d = DONE;
                        end else if (i_Chart_Data[GAP_LSB +: GAP_W] == '0) begin
                            state_d = SPAWN;
                        end else begin
                            gap_d   = i_Chart_Data[GAP_LSB +: GAP_W];
                            state_d = WAIT;
                        end
                    end
                end
                WAIT: begin
                    // tick is already suppressed while paused
                    if (tick) begin
                        gap_d = gap_q - GAP_W'(1);
                        if (gap_q == GAP_W'(1)) state_d = SPAWN;
                    end
                end
                SPAWN: begin
                    if (!i_Pause) begin
                        spawn_d = mask_q;
                        if (&addr_q) begin
                            state_d = DONE;
                        end else begin
                            addr_d  = addr_q + CHART_AW'(1);
                            state_d = FETCH;
                        end
                    end
                end
                DONE: begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d    = (state_d != IDLE);
        beat_d    = tick && !i_Abort;
        gen_clear = (state_d == IDLE);
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            gap_q   <= '0;
            mask_q  <= '0;
            spawn_q <= '0;
            beat_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            gap_q   <= gap_d;
            mask_q  <= mask_d;
            spawn_q <= spawn_d;
            beat_q  <= beat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_Chart_Addr = addr_q;
    assign o_Spawn      = spawn_q;
    assign o_Beat_Tick  = beat_q;
    assign o_Busy       = busy_q;
    assign o_Done       = done_q;

endmodule

// File: tb/tb_note_scheduler.sv
// Directed bench for note_scheduler at CLK_HZ=1000, TICK_HZ=100 (DIV=10).
// Cycle k means the clock period following the k-th edge after the start edge.
module tb_note_scheduler;

    localparam int CLK_HZ  = 1000;
    localparam int TICK_HZ = 100;
    localparam int WIN     = 120;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        pause = 1'b0;
    logic [1:0]  speed = 2'd0;
    logic [7:0]  addr;
    logic [15:0] rom_q;
    logic [3:0]  spawn;
    logic        beat, busy, done;
    logic [15:0] rom [256];

    logic        start2 = 1'b0;
    logic        abort2 = 1'b0;
    logic        pause2 = 1'b0;
    logic [1:0]  speed2 = 2'd0;
    logic [1:0]  addr2;
    logic [15:0] rom2_q;
    logic [3:0]  spawn2;
    logic        beat2, busy2, done2;

    always #5 clk = ~clk;

    always @(posedge clk) rom_q <= rom[addr];
    always @(posedge clk) rom2_q <= 16'h0F00;

    note_scheduler #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .CHART_AW(8), .LANES(4)) dut (
        .i_Clk(clk), .i_Rst(rst), .i_Start(start), .i_Abort(abort), .i_Pause(pause),
        .i_Speed(speed), .o_Chart_Addr(addr), .i_Chart_Data(rom_q), .o_Spawn(spawn),
        .o_Beat_Tick(beat), .o_Busy(busy), .o_Done(done)
    );

    note_scheduler #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .CHART_AW(2), .LANES(4)) dut2 (
        .i_Clk(clk), .i_Rst(rst), .i_Start(start2), .i_Abort(abort2), .i_Pause(pause2),
        .i_Speed(speed2), .o_Chart_Addr(addr2), .i_Chart_Data(rom2_q), .o_Spawn(spawn2),
        .o_Beat_Tick(beat2), .o_Busy(busy2), .o_Done(done2)
    );

    typedef struct {
        logic [15:0] e0, e1, e2;
        logic [1:0]  speed;
        int pause_at, pause_len, abort_at, restart_at;
        int x_cnt, x_s0, x_m0, x_s1, x_m1, x_done, x_t0, x_t1, x_t2, x_addr;
    } vec_t;

    vec_t vecs [9];
    int   n_chk  = 0;
    int   n_pass = 0;

    int sp_cyc [4];
    int sp_mask [4];
    int sp_n, dn_cyc, tk_n, busy0, bad_busy;
    int tk [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        for (int i = 0; i < 256; i++) rom[i] = 16'h8000;
        rom[0] = v.e0;
        rom[1] = v.e1;
        rom[2] = v.e2;
        speed  = v.speed;
        sp_n = 0; dn_cyc = -1; tk_n = 0; busy0 = 0; bad_busy = 0;
        for (int i = 0; i < 4; i++) begin sp_cyc[i] = -1; sp_mask[i] = 0; end
        for (int i = 0; i < 3; i++) tk[i] = -1;

        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < WIN; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 0) busy0 = int'(busy);
            if (spawn != 4'd0) begin
                if (sp_n < 4) begin sp_cyc[sp_n] = k; sp_mask[sp_n] = int'(spawn); end
                sp_n++;
            end
            if (done) begin
                if (dn_cyc < 0) dn_cyc = k;
                if (busy) bad_busy++;
            end
            if (beat && tk_n < 3) begin tk[tk_n] = k; tk_n++; end
            // inputs set here are sampled by the edge that ends cycle k
            pause = (v.pause_at >= 0) && (k >= v.pause_at) && (k < v.pause_at + v.pause_len);
            abort = (k == v.abort_at);
            start = (k == v.restart_at);
        end
        pause = 1'b0; abort = 1'b0; start = 1'b0;

        check($sformatf("v%0d.busy_rise", idx), busy0, 1);
        check($sformatf("v%0d.spawn_cnt", idx), sp_n, v.x_cnt);
        check($sformatf("v%0d.spawn0_cyc", idx), sp_cyc[0], v.x_s0);
        check($sformatf("v%0d.spawn0_mask", idx), sp_mask[0], v.x_m0);
        check($sformatf("v%0d.spawn1_cyc", idx), sp_cyc[1], v.x_s1);
        check($sformatf("v%0d.spawn1_mask", idx), sp_mask[1], v.x_m1);
        check($sformatf("v%0d.done_cyc", idx), dn_cyc, v.x_done);
        check($sformatf("v%0d.tick0", idx), tk[0], v.x_t0);
        check($sformatf("v%0d.tick1", idx), tk[1], v.x_t1);
        check($sformatf("v%0d.tick2", idx), tk[2], v.x_t2);
        check($sformatf("v%0d.busy_end", idx), 32'(busy), 0);
        check($sformatf("v%0d.addr_end", idx), 32'(addr), v.x_addr);
        check($sformatf("v%0d.busy_with_done", idx), bad_busy, 0);
    endtask

    initial begin
        int cnt, first, last, dcyc, badm, wrap, prev, act;

        //          e0        e1        e2        spd  pa  pl  ab  rs  cnt s0  m0 s1  m1 done t0  t1  t2  addr
        vecs[0] = '{16'h0100, 16'h8000, 16'h8000, 2'd0, -1, 0, -1, -1, 1,  3, 1, -1, 0,  6, -1, -1, -1, 1};
        vecs[1] = '{16'h0205, 16'h8000, 16'h8000, 2'd0, -1, 0, -1, -1, 1, 52, 2, -1, 0, 55, 11, 21, 31, 1};
        vecs[2] = '{16'h0805, 16'h8000, 16'h8000, 2'd3, -1, 0, -1, -1, 1, 15, 8, -1, 0, 18,  4,  6,  9, 1};
        vecs[3] = '{16'h0205, 16'h8000, 16'h8000, 2'd0, 25, 40, -1, -1, 1, 92, 2, -1, 0, 95, 11, 21, 71, 1};
        vecs[4] = '{16'h0100, 16'h0205, 16'h8000, 2'd0, -1, 0, 25, -1, 1,  3, 1, -1, 0, -1, 11, 21, -1, 0};
        vecs[5] = '{16'h0100, 16'h0200, 16'h8000, 2'd0, -1, 0, -1,  4, 2,  3, 1,  6, 2,  9, -1, -1, -1, 2};
        vecs[6] = '{16'h7000, 16'h0300, 16'h8000, 2'd0, -1, 0, -1, -1, 1,  6, 3, -1, 0,  9, -1, -1, -1, 2};
        vecs[7] = '{16'h0401, 16'h8000, 16'h8000, 2'd1, -1, 0, -1, -1, 1,  7, 4, -1, 0, 10,  6, -1, -1, 1};
        vecs[8] = '{16'h0100, 16'h8000, 16'h8000, 2'd0,  2, 5, -1, -1, 1,  8, 1, -1, 0, 11, -1, -1, -1, 1};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst.addr", 32'(addr), 0);
        check("rst.spawn", 32'(spawn), 0);
        check("rst.beat", 32'(beat), 0);
        check("rst.busy", 32'(busy), 0);
        check("rst.done", 32'(done), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Abort and start in the same cycle: abort wins, address clears
        for (int i = 0; i < 256; i++) rom[i] = 16'h0100;
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        check("abort_start.busy", 32'(busy), 0);
        check("abort_start.addr", 32'(addr), 0);
        act = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (busy || done || spawn != 4'd0) act++;
        end
        check("abort_start.activity", act, 0);

        // Four-entry chart without END: all entries spawn, then done
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        cnt = 0; first = -1; last = -1; dcyc = -1; badm = 0; wrap = 0; prev = 0;
        for (int k = 0; k < 30; k++) begin
            if (k > 0) @(negedge clk);
            if (spawn2 != 4'd0) begin
                if (first < 0) first = k;
                last = k;
                cnt++;
                if (spawn2 != 4'hF) badm++;
            end
            if (done2 && dcyc < 0) dcyc = k;
            if (busy2 && int'(addr2) < prev) wrap++;
            prev = int'(addr2);
        end
        check("aw2.spawn_cnt", cnt, 4);
        check("aw2.first_spawn", first, 3);
        check("aw2.last_spawn", last, 12);
        check("aw2.done_cyc", dcyc, 13);
        check("aw2.bad_mask", badm, 0);
        check("aw2.addr_wrap", wrap, 0);
        check("aw2.addr_end", 32'(addr2), 3);
        check("aw2.busy_end", 32'(busy2), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/note_scheduler.md
# note_scheduler

Chart sequencer for the rhythm game. It walks an external chart ROM entry by entry and waits a programmed number of beat ticks before each entry. It then emits a one-cycle spawn pulse per lane, which the game logic uses to inject notes into the dot-matrix lanes. It sits between the start, pause and speed controls and the note/judgement datapath, and it is the only block that decides when notes appear.

## Interface
- CLK_HZ, 50_000_000, system clock frequency.
- TICK_HZ, 100, beat-tick rate at 1x speed.
- CHART_AW, 8, chart ROM address width.
- LANES, 4, number of note lanes; fixed at 4 in this revision.
- i_Clk  in  1  system clock (CLOCK_50 domain); the only clock.
- i_Rst  in  1  reset, asynchronous, active-high.
- i_Start  in  1  single-cycle start request, sampled only in IDLE.
- i_Abort  in  1  level; returns the block to IDLE from any state.
- i_Pause  in  1  level; freezes sequencing while high.
- i_Speed  in  2  0..3 selects 1x..4x tick rate.
- o_Chart_Addr  out  CHART_AW  chart ROM address.
- i_Chart_Data  in  16  ROM data, valid one cycle after the address (synchronous ROM).
- o_Spawn  out  LANES  one-cycle pulse carrying the lane mask of the spawned entry.
- o_Beat_Tick  out  1  one-cycle pulse per beat tick; the same tick drives note fall.
- o_Busy  out  1  high in every state except IDLE.
- o_Done  out  1  one-cycle pulse when the chart completes normally.

## Operation
- Chart entry format: bit 15 = END; bits 14:12 reserved (ignored); bits 11:8 = lane mask; bits 7:0 = GAP in ticks.
- Tick generator:
  - DIV = CLK_HZ/TICK_HZ.
  - Each cycle, acc += i_Speed+1.
  - When acc >= DIV: acc -= DIV and o_Beat_Tick pulses.
  - acc is at least clog2(DIV+4) bits wide and never overflows.
  - The tick generator runs only when the state is not IDLE and i_Pause=0.
  - acc clears on IDLE entry.
- FSM states:
  - IDLE: on i_Start, go to FETCH and set addr=0.
  - FETCH: drive addr; go to LOAD.
  - LOAD: latch the entry.
    - If END: go to DONE.
    - Else if GAP=0: go to SPAWN.
    - Else: load gap_cnt=GAP and go to WAIT.
  - WAIT: decrement gap_cnt on each tick. When a tick arrives with gap_cnt=1, go to SPAWN.
  - SPAWN: pulse o_Spawn=mask.
    - If addr = 2^CHART_AW-1: go to DONE.
    - Else: addr++ and go to FETCH.
  - DONE: pulse o_Done; go to IDLE.
- A lane mask of 0 is legal: the entry is a rest, and o_Spawn pulses 0, which is effectively no pulse.
- Pause:
  - While i_Pause=1 the FSM holds in its current state; no tick and no spawn occur.
  - IDLE and DONE ignore pause.
  - A SPAWN that is held by pause fires in the first cycle after pause deasserts.
- Abort:
  - Any state goes to IDLE on the next edge, with no o_Done and no o_Spawn.
  - addr and acc clear.
  - Abort overrides pause.
  - If start and abort arrive in the same cycle, abort wins and the block stays in IDLE.
- i_Start while busy is ignored. A restart is required to replay the chart.
- i_Speed may change mid-chart and takes effect on the next accumulate; acc is not reset.

## Timing
- Reset values: state=IDLE, o_Chart_Addr=0, o_Spawn=0, o_Beat_Tick=0, o_Busy=0, o_Done=0, acc=0, gap_cnt=0.
- All outputs are registered.
- Start sampled at edge E0 gives FETCH after E0, LOAD after E1, decision at E2.
  - For GAP=0, o_Spawn is high for the single cycle following E3.
  - o_Busy rises in the cycle after E0.
- With GAP=g>0, o_Spawn goes high in the cycle following the edge after the g-th tick counted from the LOAD state.
- Per-entry overhead outside WAIT is 3 cycles (FETCH, LOAD, SPAWN). Back-to-back GAP=0 entries therefore spawn every 3 cycles.
- o_Done is high for 1 cycle; o_Busy falls in the same cycle that o_Done is high.

## Structure
- The shared package rhythm_pkg holds:
  - the state encoding (IDLE, FETCH, LOAD, WAIT, SPAWN, DONE)
  - the entry field bit positions (END, MASK, GAP)
  - the LANES constant
  - the speed code constants
- Sub-module beat_tick_gen contains the accumulator prescaler. It has ports for clock, reset, enable, clear, i_Speed and o_Tick.

## Test plan
All scenarios use CLK_HZ=1000 and TICK_HZ=100, so DIV=10.
- Reset then start with ROM[0]={END=0, mask=4'b0001, GAP=0} and ROM[1]=END → o_Spawn=0001 exactly 3 cycles after the start edge, then o_Done 3 cycles later, and o_Busy low afterwards.
- ROM[0] GAP=5, speed=0 → spawn 1 cycle after the 5th o_Beat_Tick; ticks are spaced 10 cycles apart. Repeat with speed=3 → ticks alternate between 2 and 3 cycles apart (mean 2.5).
- Pause held for 40 cycles during WAIT → no ticks and gap_cnt frozen; the spawn is delayed by exactly 40 cycles relative to the unpaused run.
- Abort asserted in WAIT, and separately on the same cycle as start → IDLE next cycle, o_Done never pulses, o_Chart_Addr=0, and no spawn occurs.
- CHART_AW=2 with no END entry, all masks 1111 → exactly 4 spawns followed by o_Done; o_Chart_Addr never wraps past 3.
- i_Start pulsed while busy → ignored: the spawn sequence and addresses are identical to a single-start run.
